// File: rtl/frequency_window_controller.sv
// frequency_window_controller
// Runs one clear / measure / flush window on a frequency_analyzer, captures
// its three accumulators and classifies the window as f0, f1 or undecided.
// Windows can be chained back-to-back for FSK demodulation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting configuration, waiting for start
// CLEAR   | analyzer held in clear for CLEAR_CYCLES clocks
// MEASURE | analyzer enabled for the latched window length
// FLUSH   | enable dropped for 2 clocks so partial counts settle
// RESULT  | result presented, waiting for result_ready
module frequency_window_controller #(
  parameter int unsigned DEFAULT_WINDOW_TICKS = 50000,
  parameter int unsigned CLEAR_CYCLES         = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_f0,
  input  logic [31:0] cfg_f1,
  input  logic [31:0] cfg_f0_deviation,
  input  logic [31:0] cfg_f1_deviation,
  input  logic [31:0] cfg_window,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  output logic        busy,
  output logic        an_clear,
  output logic        an_enable,
  output logic [31:0] an_f0,
  output logic [31:0] an_f1,
  output logic [31:0] an_f0_deviation,
  output logic [31:0] an_f1_deviation,
  input  logic [31:0] an_f0_value,
  input  logic [31:0] an_f1_value,
  input  logic [31:0] an_unknown,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_f0,
  output logic [31:0] result_f1,
  output logic [31:0] result_unknown,
  output logic [1:0]  result_symbol
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_MEASURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_RESULT  = 3'd4
  } state_t;

  localparam logic [31:0] CLEAR_LOAD   = 32'(CLEAR_CYCLES);
  localparam logic [31:0] DEFAULT_LOAD = 32'(DEFAULT_WINDOW_TICKS);
  localparam logic [31:0] FLUSH_LOAD   = 32'd2;

  localparam logic [1:0] SYM_F0   = 2'd0;
  localparam logic [1:0] SYM_F1   = 2'd1;
  localparam logic [1:0] SYM_NONE = 2'd2;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] timer;
  logic [31:0] timer_nxt;
  logic [31:0] window_q;
  logic        cfg_take;
  logic        capture;
  logic [33:0] sum34;
  logic [33:0] f0_x2;
  logic [33:0] f1_x2;
  logic [1:0]  symbol_nxt;

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign cfg_take  = cfg_ready & cfg_valid;
  // Only a normal FLUSH -> RESULT transition captures; abort never does.
  assign capture   = (state == S_FLUSH) && (state_nxt == S_RESULT);

  // Next-state and timer reload; a single down-counter serves every timed
  // state and is reloaded with that state's length on entry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          timer_nxt = CLEAR_LOAD;
        end
      end
      S_CLEAR: begin
        if (timer == 32'd1) begin
          state_nxt = S_MEASURE;
          timer_nxt = window_q;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      S_MEASURE: begin
        if (timer == 32'd1) begin
          state_nxt = S_FLUSH;
          timer_nxt = FLUSH_LOAD;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      S_FLUSH: begin
        if (timer == 32'd1) begin
          state_nxt = S_RESULT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          if (continuous) begin
            state_nxt = S_CLEAR;
            timer_nxt = CLEAR_LOAD;
          end else begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
    end
  end

  // Classification in 34 bits so the sum of three full-range accumulators
  // and the doubled winner never wrap.
  always_comb begin
    sum34      = {2'b00, an_f0_value} + {2'b00, an_f1_value} + {2'b00, an_unknown};
    f0_x2      = {1'b0, an_f0_value, 1'b0};
    f1_x2      = {1'b0, an_f1_value, 1'b0};
    symbol_nxt = SYM_NONE;
    if ((an_f0_value > an_f1_value) && (f0_x2 >= sum34)) begin
      symbol_nxt = SYM_F0;
    end else if ((an_f1_value > an_f0_value) && (f1_x2 >= sum34)) begin
      symbol_nxt = SYM_F1;
    end
  end

  // State register with analyzer controls registered from the next state,
  // so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      an_clear     <= 1'b0;
      an_enable    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      an_clear     <= (state_nxt == S_MEASURE) || (state_nxt == S_FLUSH) ||
                      (state_nxt == S_RESULT);
      an_enable    <= (state_nxt == S_MEASURE);
      result_valid <= (state_nxt == S_RESULT);
    end
  end

  // Configuration latch; a zero window selects the default length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_f0           <= '0;
      an_f1           <= '0;
      an_f0_deviation <= '0;
      an_f1_deviation <= '0;
      window_q        <= '0;
    end else if (cfg_take) begin
      an_f0           <= cfg_f0;
      an_f1           <= cfg_f1;
      an_f0_deviation <= cfg_f0_deviation;
      an_f1_deviation <= cfg_f1_deviation;
      window_q        <= (cfg_window == 32'd0) ? DEFAULT_LOAD : cfg_window;
    end
  end

  // Result capture on the edge that ends FLUSH; held through RESULT and after.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_f0      <= '0;
      result_f1      <= '0;
      result_unknown <= '0;
      result_symbol  <= SYM_F0;
    end else if (capture) begin
      result_f0      <= an_f0_value;
      result_f1      <= an_f1_value;
      result_unknown <= an_unknown;
      result_symbol  <= symbol_nxt;
    end
  end

endmodule

// File: doc/frequency_window_controller.md
# frequency_window_controller

Measurement sequencer for `frequency_analyzer`. It latches a tick-domain configuration and drives the analyzer's `clear`, `enable` and configuration inputs through one fixed-length measurement window. At the end of the window it captures the analyzer's three accumulators and classifies the window as an f0 symbol, an f1 symbol or undecided. It sits between the register/CPU side, which issues configuration and start, and the analyzer, and it can run windows back-to-back for FSK demodulation.

## Interface
Parameters:
- `DEFAULT_WINDOW_TICKS`, 50000: window length in clocks, used when `cfg_window` is 0.
- `CLEAR_CYCLES`, 2: clocks that `an_clear` is held low before each window; must be ≥1.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high.
- `cfg_valid` in 1, `cfg_ready` out 1: configuration handshake.
- `cfg_f0`, `cfg_f1`, `cfg_f0_deviation`, `cfg_f1_deviation` in 32 each: half-period values and deviations, already in ticks. Zero means "analyzer default".
- `cfg_window` in 32: window length in clocks; 0 selects `DEFAULT_WINDOW_TICKS`.
- `start` in 1: level, sampled only in IDLE.
- `continuous` in 1: re-arm after each accepted result.
- `abort` in 1: return to IDLE from any state.
- `busy` out 1: high when state ≠ IDLE.
- `an_clear` out 1: active-low clear to the analyzer.
- `an_enable` out 1: enable to the analyzer.
- `an_f0`, `an_f1`, `an_f0_deviation`, `an_f1_deviation` out 32: configuration to the analyzer.
- `an_f0_value`, `an_f1_value`, `an_unknown` in 32: analyzer accumulators.
- `result_valid` out 1, `result_ready` in 1: result handshake.
- `result_f0`, `result_f1`, `result_unknown` out 32: captured accumulators.
- `result_symbol` out 2: 0 = f0, 1 = f1, 2 = undecided.

## Operation
- The FSM has five states: IDLE, CLEAR, MEASURE, FLUSH, RESULT.
- **IDLE**
  - `cfg_ready`=1.
  - `cfg_valid` latches all `cfg_*` fields into registers. A zero `cfg_window` is stored as `DEFAULT_WINDOW_TICKS`.
  - `an_clear`=0, `an_enable`=0.
  - `start`=1 moves to CLEAR. If `cfg_valid` and `start` are both asserted in the same cycle, the new configuration is used.
- **CLEAR**
  - `an_clear`=0 for exactly `CLEAR_CYCLES` clocks, then go to MEASURE.
- **MEASURE**
  - `an_clear`=1, `an_enable`=1 for exactly W clocks, where W is the latched window.
  - A down-counter loaded with W counts the window; at 1, go to FLUSH.
- **FLUSH**
  - `an_clear`=1, `an_enable`=0 for 2 clocks. This lets the analyzer fold its partial count into `an_unknown`.
  - On the edge that ends FLUSH, capture `result_f0`/`result_f1`/`result_unknown` from the analyzer, compute `result_symbol`, and go to RESULT.
- **RESULT**
  - `result_valid`=1; results are held stable.
  - On `result_valid & result_ready`: go to CLEAR if `continuous`=1, else IDLE. Then `result_valid`=0.
  - While `result_ready`=0 the block stalls and no new window starts.
- **Outputs and config ports**
  - `an_f*` outputs are the latched configuration registers at all times.
  - Configuration cannot change outside IDLE because `cfg_ready`=0 there.
- **Classification** (34-bit unsigned arithmetic, S = f0 + f1 + unknown)
  - symbol 0 if f0 > f1 and 2·f0 ≥ S.
  - symbol 1 if f1 > f0 and 2·f1 ≥ S.
  - symbol 2 otherwise. This includes f0 == f1, and S == 0.
- **abort**
  - Takes priority over every other transition.
  - Next state is IDLE, `result_valid`=0, `an_enable`=0, `an_clear`=0.
  - Latched configuration is kept; the result registers are not updated.
- **reset** (async, active-high)
  - State IDLE.
  - All config and result registers 0, `result_symbol`=0.
  - `an_clear`=0, `an_enable`=0, `result_valid`=0, `busy`=0.
  - `cfg_ready`=1 once `reset` is released.
  - Reset mid-window aborts the window immediately.

## Timing
- All outputs are registered except `cfg_ready` and `busy`, which decode the state.
- With the edge sampling `start` as cycle 0:
  - `an_clear` is low in cycles 0..C−1.
  - `an_enable` is high in cycles C..C+W−1.
  - `result_valid` rises at cycle C+W+2.
  - C = `CLEAR_CYCLES`.
- In continuous mode, a handshake at cycle T puts CLEAR in cycle T+1. The next `result_valid` is at T+1+C+W+2.
- W=1 is legal: exactly one enable cycle.
- Window counter: 32-bit. W=0xFFFF_FFFF runs the full count without wrap.

## Test plan
- Reset with no stimulus → `an_clear`=0, `an_enable`=0, `result_valid`=0, `busy`=0, `cfg_ready`=1, all result buses 0.
- Configure f0=10, f0_dev=1, f1=5, f1_dev=1, window=100; start; analyzer `sample_data` toggles every 10 clocks → `an_enable` high for exactly 100 cycles; `result_valid` at cycle 104; `result_f0` ≥80; f0+f1+unknown = 100; symbol 0.
- Same configuration, `sample_data` toggling every 5 clocks → `result_f1` ≥80, symbol 1. A constant `sample_data` gives unknown=100, symbol 2.
- `cfg_window`=0, C=2 → window lasts `DEFAULT_WINDOW_TICKS` cycles. Simultaneous `cfg_valid`+`start` → the new f0 appears on `an_f0` before the first enable cycle.
- `continuous`=1 with `result_ready` held low for 50 cycles → results held stable and `an_enable` stays 0. Release `result_ready` → CLEAR begins the next cycle; the second result matches the first for the same stimulus.
- `abort` in cycle 40 of a 100-cycle window → IDLE the next cycle, `an_enable`=0, no `result_valid`. A subsequent start produces a clean window with totals equal to 100.
